mem_wb_cycle: RTL and testbench

- Memory-access plus writeback stage of the 5-stage RISC-V pipeline.
- Accepts M-stage control and data, performs loads and stores over a ready-based data-memory handshake, and stalls the pipeline while memory is busy.
- Registers the M/W pipeline boundary and drives the writeback interface (RegWriteW, RdW, ResultW) that feeds the register-file write port in decode.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/dmem_ctrl.sv | 72 +++++++
 rtl/mem_wb_cycle.sv | 91 +++++++++
 tb/tb_mem_wb_cycle.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared encodings for the M/W pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } dmem_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module   : dmem_ctrl
// Brief    : Data-memory handshake FSM, stall generation, misalignment detect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl
  import pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidM,
  input  logic             MemWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  WriteDataM,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ready,
  output logic             StallM,
  output logic             misaligned,
  output logic [CNT_W-1:0] StallCount
);

  dmem_state_t r_state;
  dmem_state_t w_nextState;
  logic        w_memOp;

  assign w_memOp    = ValidM & (MemWriteM | (ResultSrcM == RES_MEM));
  assign misaligned = w_memOp & (ALUResultM[1:0] != 2'b00);

  // Reset gates the request so an in-flight access is abandoned immediately.
  assign dmem_req   = w_memOp & ~misaligned & ~rst;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = ALUResultM;
  assign dmem_wdata = WriteDataM;
  assign StallM     = dmem_req & ~dmem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (dmem_req && !dmem_ready) w_nextState = S_WAIT;
      S_WAIT: if (!dmem_req || dmem_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
    end else if (StallM && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_cycle.sv
// ============================================================================
// Module   : mem_wb_cycle
// Brief    : Memory-access plus writeback stage; owns the M/W register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_cycle
  import pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidM,
  input  logic             RegWriteM,
  input  logic             MemWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [4:0]       RdM,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  WriteDataM,
  input  logic [XLEN-1:0]  PCPlus4M,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ready,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             StallM,
  output logic             RegWriteW,
  output logic [4:0]       RdW,
  output logic [XLEN-1:0]  ResultW,
  output logic             MisalignW,
  output logic [CNT_W-1:0] StallCount
);

  logic            w_misaligned;
  logic [XLEN-1:0] w_result;

  dmem_ctrl #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_dmem_ctrl (
    .clk        (clk),
    .rst        (rst),
    .ValidM     (ValidM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .StallM     (StallM),
    .misaligned (w_misaligned),
    .StallCount (StallCount)
  );

  always_comb begin
    w_result = ALUResultM;
    case (ResultSrcM)
      RES_MEM: w_result = dmem_rdata;
      RES_PC4: w_result = PCPlus4M;
      default: w_result = ALUResultM;
    endcase
  end

  // A stalled cycle pushes a bubble; RdW/ResultW keep their old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      RdW       <= '0;
      ResultW   <= '0;
      MisalignW <= 1'b0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
      MisalignW <= 1'b0;
    end else begin
      RegWriteW <= ValidM & RegWriteM & (RdM != 5'd0) & ~w_misaligned;
      RdW       <= RdM;
      ResultW   <= w_result;
      MisalignW <= w_misaligned;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_cycle.sv
// ============================================================================
// Module   : tb_mem_wb_cycle
// Brief    : Directed self-checking bench for mem_wb_cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM, RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        StallM, RegWriteW, MisalignW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [31:0] StallCount;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  mem_wb_cycle #(.XLEN(32), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ValidM     (ValidM),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .StallM     (StallM),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .MisalignW  (MisalignW),
    .StallCount (StallCount)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setM(input logic v, input logic rw, input logic mw, input logic [1:0] src,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
    ValidM = v; RegWriteM = rw; MemWriteM = mw; ResultSrcM = src;
    RdM = rd; ALUResultM = alu; WriteDataM = wd;
  endtask

  initial begin
    rst = 1'b1;
    setM(0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
    PCPlus4M = 32'h0000_1004;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_regwrite", RegWriteW, 0);
    check("rst_rd", RdW, 0);
    check("rst_result", ResultW, 0);
    check("rst_misalign", MisalignW, 0);
    check("rst_stallcnt", StallCount, 0);
    check("rst_req", dmem_req, 0);

    // ALU writeback
    setM(1, 1, 0, 2'b00, 5'd5, 32'h1234, 32'h0);
    #1;
    check("alu_req", dmem_req, 0);
    check("alu_stall", StallM, 0);
    tick();
    check("alu_regwrite", RegWriteW, 1);
    check("alu_rd", RdW, 5);
    check("alu_result", ResultW, 32'h1234);

    // PC+4 select
    setM(1, 1, 0, 2'b10, 5'd1, 32'h9999, 32'h0);
    tick();
    check("pc4_result", ResultW, 32'h0000_1004);

    // zero-wait load
    setM(1, 1, 0, 2'b01, 5'd7, 32'h100, 32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    check("ld0_req", dmem_req, 1);
    check("ld0_we", dmem_we, 0);
    check("ld0_addr", dmem_addr, 32'h100);
    check("ld0_stall", StallM, 0);
    tick();
    check("ld0_result", ResultW, 32'hDEADBEEF);
    check("ld0_rd", RdW, 7);
    check("ld0_regwrite", RegWriteW, 1);

    // load with three wait cycles
    setM(1, 1, 0, 2'b01, 5'd9, 32'h104, 32'h0);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ld3_stall", StallM, 1);
      check("ld3_req", dmem_req, 1);
      tick();
      check("ld3_bubble", RegWriteW, 0);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h11223344;
    #1;
    check("ld3_stall_end", StallM, 0);
    tick();
    check("ld3_regwrite", RegWriteW, 1);
    check("ld3_rd", RdW, 9);
    check("ld3_result", ResultW, 32'h11223344);
    check("ld3_stallcnt", StallCount, 3);

    // store
    setM(1, 0, 1, 2'b00, 5'd2, 32'h200, 32'hA5A5A5A5);
    #1;
    check("st_req", dmem_req, 1);
    check("st_we", dmem_we, 1);
    check("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    check("st_stall", StallM, 0);
    tick();
    check("st_regwrite", RegWriteW, 0);

    // write to x0 is suppressed
    setM(1, 1, 0, 2'b00, 5'd0, 32'h55, 32'h0);
    tick();
    check("x0_regwrite", RegWriteW, 0);

    // misaligned load
    setM(1, 1, 0, 2'b01, 5'd3, 32'h102, 32'h0);
    dmem_ready = 1'b0;
    #1;
    check("mis_req", dmem_req, 0);
    check("mis_stall", StallM, 0);
    tick();
    check("mis_pulse", MisalignW, 1);
    check("mis_regwrite", RegWriteW, 0);
    setM(1, 1, 0, 2'b00, 5'd4, 32'h77, 32'h0);
    tick();
    check("mis_pulse_end", MisalignW, 0);
    check("mis_next_regwrite", RegWriteW, 1);
    check("mis_stallcnt", StallCount, 3);

    // reset on the second wait cycle
    setM(1, 1, 0, 2'b01, 5'd6, 32'h300, 32'h0);
    dmem_ready = 1'b0;
    #1;
    check("rw_stall", StallM, 1);
    tick();
    rst = 1'b1;
    #1;
    check("rw_req_in_rst", dmem_req, 0);
    tick();
    rst = 1'b0;
    setM(0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
    #1;
    check("rw_regwrite", RegWriteW, 0);
    check("rw_rd", RdW, 0);
    check("rw_result", ResultW, 0);
    check("rw_misalign", MisalignW, 0);
    check("rw_stallcnt", StallCount, 0);
    check("rw_req", dmem_req, 0);

    // load right after reset completes normally
    setM(1, 1, 0, 2'b01, 5'd8, 32'h400, 32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    #1;
    check("post_req", dmem_req, 1);
    check("post_stall", StallM, 0);
    tick();
    check("post_regwrite", RegWriteW, 1);
    check("post_rd", RdW, 8);
    check("post_result", ResultW, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

`default_nettype wire
